// File: rtl/data_ram_responder_if.sv
// ---------------------------------------------------------------------------
// data_ram_responder_if
//   MEM-stage RAM port between the MIPS core (master) and the data memory
//   (slave).
//
//   Transfer semantics: there is no valid/ready pair. Every request that is
//   presented in a cycle completes in that cycle. ram_read and ram_write are
//   the request qualifiers. ram_word is combinational from the current
//   request, and the core captures it at the next rising clk edge.
//
//   Signals
//     ram_read   master->slave  read request this cycle
//     ram_write  master->slave  write request this cycle
//     ram_adr    master->slave  byte address
//     ram_data   master->slave  write data
//     ram_word   slave->master  read data
// ---------------------------------------------------------------------------
interface data_ram_responder_if;
    logic        ram_read;
    logic        ram_write;
    logic [31:0] ram_adr;
    logic [31:0] ram_data;
    logic [31:0] ram_word;

    modport master (
        output ram_read,
        output ram_write,
        output ram_adr,
        output ram_data,
        input  ram_word
    );

    modport slave (
        input  ram_read,
        input  ram_write,
        input  ram_adr,
        input  ram_data,
        output ram_word
    );
endinterface

// File: rtl/data_ram_responder.sv
// ---------------------------------------------------------------------------
// data_ram_responder
//   Data-memory slave for the MIPS MEM stage. The array is word-addressed and
//   has a one-entry posted-write buffer with read forwarding. A two-word MMIO
//   window provides a free-running cycle counter (CNT) and a sticky error
//   status register (STAT).
//
//   Ports
//     clk           rising-edge clock
//     rst           synchronous reset, active-high
//     bus           RAM port (slave modport): read/write/adr/data in, word out
//     misalign_err  sticky flag: an access had ram_adr[1:0] != 0
//     range_err     sticky flag: an access fell outside the array and the
//                   MMIO window, or read and write were requested together
// ---------------------------------------------------------------------------
module data_ram_responder #(
    parameter int          ADDR_BITS = 10,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    data_ram_responder_if.slave   bus,
    output logic                  misalign_err,
    output logic                  range_err
);

    localparam int          DEPTH    = 1 << ADDR_BITS;
    localparam logic [31:0] STAT_ADR = MMIO_BASE + 32'd4;

    logic [31:0]          mem [0:DEPTH-1];

    logic                 wbuf_valid;
    logic [ADDR_BITS-1:0] wbuf_idx;
    logic [31:0]          wbuf_data;
    logic [31:0]          counter;

    // Address decode
    logic [ADDR_BITS-1:0] idx;
    logic                 aligned;
    logic                 array_hit;
    logic                 cnt_hit;
    logic                 stat_hit;
    logic                 mapped;
    logic                 access;
    logic                 both;
    logic                 wr_ok;
    logic                 array_wr;
    logic                 cnt_wr;
    logic                 stat_wr;
    logic                 set_misalign;
    logic                 set_range;

    assign idx       = bus.ram_adr[ADDR_BITS+1:2];
    assign aligned   = (bus.ram_adr[1:0] == 2'b00);
    assign array_hit = (bus.ram_adr[31:ADDR_BITS+2] == '0);
    assign cnt_hit   = (bus.ram_adr == MMIO_BASE);
    assign stat_hit  = (bus.ram_adr == STAT_ADR);
    assign mapped    = array_hit | cnt_hit | stat_hit;
    assign access    = bus.ram_read | bus.ram_write;
    assign both      = bus.ram_read & bus.ram_write;

    // A simultaneous read+write is served as a read only, so any write
    // side effect requires ram_read to be low.
    assign wr_ok     = bus.ram_write & ~bus.ram_read & aligned;
    assign array_wr  = wr_ok & array_hit;
    assign cnt_wr    = wr_ok & cnt_hit;
    assign stat_wr   = wr_ok & stat_hit;

    assign set_misalign = access & ~aligned;
    assign set_range    = (access & ~mapped) | both;

    // Read path: combinational from the current request.
    always_comb begin
        bus.ram_word = 32'h0;
        if (!rst && bus.ram_read) begin
            if (!aligned) begin
                bus.ram_word = 32'h0;
            end else if (cnt_hit) begin
                // Pre-increment value: the counter register has not yet
                // stepped for this cycle.
                bus.ram_word = counter;
            end else if (stat_hit) begin
                bus.ram_word = {30'b0, range_err, misalign_err};
            end else if (array_hit) begin
                // The buffered write has not reached the array yet, so it
                // must be forwarded to a read of the same word.
                if (wbuf_valid && (wbuf_idx == idx)) begin
                    bus.ram_word = wbuf_data;
                end else begin
                    bus.ram_word = mem[idx];
                end
            end
        end
    end

    // Control state: write buffer, counter, sticky errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            wbuf_valid   <= 1'b0;
            counter      <= 32'h0;
            misalign_err <= 1'b0;
            range_err    <= 1'b0;
        end else begin
            // A new array write refills the buffer on the same edge that
            // commits the previous entry, so writes never stall.
            wbuf_valid <= array_wr;
            if (array_wr) begin
                wbuf_idx  <= idx;
                wbuf_data <= bus.ram_data;
            end

            if (cnt_wr) begin
                counter <= bus.ram_data;
            end else begin
                counter <= counter + 32'd1;
            end

            // A STAT write clears the flags, but errors raised by the same
            // request still set them.
            misalign_err <= (misalign_err & ~stat_wr) | set_misalign;
            range_err    <= (range_err & ~stat_wr) | set_range;
        end
    end

    // Array commit. Suppressed under reset so a buffered write is discarded.
    always_ff @(posedge clk) begin
        if (!rst && wbuf_valid) begin
            mem[wbuf_idx] <= wbuf_data;
        end
    end

endmodule

// File: tb/tb_data_ram_responder.sv
// ---------------------------------------------------------------------------
// tb_data_ram_responder
//   Directed bench for data_ram_responder. Inputs change 1 ns after the
//   rising edge; outputs are sampled before the next rising edge.
// ---------------------------------------------------------------------------
module tb_data_ram_responder;

    localparam logic [31:0] CNT_ADR  = 32'hFFFF_0000;
    localparam logic [31:0] STAT_ADR = 32'hFFFF_0004;

    logic clk;
    logic rst;
    logic misalign_err;
    logic range_err;

    int total;
    int bad;

    data_ram_responder_if bus_if ();

    data_ram_responder #(
        .ADDR_BITS (10),
        .MMIO_BASE (32'hFFFF_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus_if),
        .misalign_err (misalign_err),
        .range_err    (range_err)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr,
                         input logic [31:0] adr, input logic [31:0] data);
        bus_if.ram_read  = rd;
        bus_if.ram_write = wr;
        bus_if.ram_adr   = adr;
        bus_if.ram_data  = data;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Reset state and counter start
    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b0, STAT_ADR, 32'h0);
        step();
        step();
        #3;
        total++;
        if (bus_if.ram_word !== 32'h0) begin
            bad++;
            $display("FAIL reset_word_zero: got %h want %h", bus_if.ram_word, 32'h0);
        end
        rst = 1'b0;
        drive(1'b1, 1'b0, CNT_ADR, 32'h0);
        #1;
        total++;
        if (bus_if.ram_word !== 32'h0) begin
            bad++;
            $display("FAIL reset_cnt0: got %h want %h", bus_if.ram_word, 32'h0);
        end
        total++;
        if (misalign_err !== 1'b0 || range_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_errs: got %b%b want 00", range_err, misalign_err);
        end
        step();
        total++;
        if (bus_if.ram_word !== 32'h1) begin
            bad++;
            $display("FAIL reset_cnt1: got %h want %h", bus_if.ram_word, 32'h1);
        end
        idle();
    endtask

    // Posted write, forwarding, then array read
    task automatic test_forwarding();
        drive(1'b0, 1'b1, 32'h10, 32'h1234_5678);
        step();
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        total++;
        if (bus_if.ram_word !== 32'h1234_5678) begin
            bad++;
            $display("FAIL fwd_read: got %h want %h", bus_if.ram_word, 32'h1234_5678);
        end
        step();
        idle();
        step();
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        total++;
        if (bus_if.ram_word !== 32'h1234_5678) begin
            bad++;
            $display("FAIL array_read: got %h want %h", bus_if.ram_word, 32'h1234_5678);
        end
        total++;
        if (misalign_err !== 1'b0 || range_err !== 1'b0) begin
            bad++;
            $display("FAIL fwd_errs: got %b%b want 00", range_err, misalign_err);
        end
        step();
        idle();
    endtask

    // Consecutive writes, same index twice then a neighbour
    task automatic test_back_to_back();
        drive(1'b0, 1'b1, 32'h20, 32'hAAAA_0001);
        step();
        drive(1'b0, 1'b1, 32'h20, 32'hBBBB_0002);
        step();
        drive(1'b0, 1'b1, 32'h24, 32'hCCCC_0003);
        step();
        drive(1'b1, 1'b0, 32'h20, 32'h0);
        #1;
        total++;
        if (bus_if.ram_word !== 32'hBBBB_0002) begin
            bad++;
            $display("FAIL b2b_last_wins: got %h want %h", bus_if.ram_word, 32'hBBBB_0002);
        end
        drive(1'b1, 1'b0, 32'h24, 32'h0);
        #1;
        total++;
        if (bus_if.ram_word !== 32'hCCCC_0003) begin
            bad++;
            $display("FAIL b2b_fwd_c: got %h want %h", bus_if.ram_word, 32'hCCCC_0003);
        end
        step();
        idle();
        step();
        drive(1'b1, 1'b0, 32'h24, 32'h0);
        #1;
        total++;
        if (bus_if.ram_word !== 32'hCCCC_0003) begin
            bad++;
            $display("FAIL b2b_array_c: got %h want %h", bus_if.ram_word, 32'hCCCC_0003);
        end
        step();
        idle();
    endtask

    // Misaligned read, sticky flag, STAT-write clear
    task automatic test_misalign();
        drive(1'b1, 1'b0, 32'h13, 32'h0);
        #1;
        total++;
        if (bus_if.ram_word !== 32'h0) begin
            bad++;
            $display("FAIL misalign_word: got %h want %h", bus_if.ram_word, 32'h0);
        end
        step();
        idle();
        #1;
        total++;
        if (misalign_err !== 1'b1 || range_err !== 1'b0) begin
            bad++;
            $display("FAIL misalign_set: got %b%b want 01", range_err, misalign_err);
        end
        step();
        total++;
        if (misalign_err !== 1'b1) begin
            bad++;
            $display("FAIL misalign_sticky: got %b want 1", misalign_err);
        end
        drive(1'b0, 1'b1, STAT_ADR, 32'h0);
        step();
        idle();
        total++;
        if (misalign_err !== 1'b0) begin
            bad++;
            $display("FAIL misalign_clear: got %b want 0", misalign_err);
        end
    endtask

    // read & write together: read only, range error
    task automatic test_read_write_conflict();
        drive(1'b0, 1'b1, 32'h40, 32'h0BAD_F00D);
        step();
        idle();
        step();
        drive(1'b1, 1'b1, 32'h40, 32'hAAAA_AAAA);
        #1;
        total++;
        if (bus_if.ram_word !== 32'h0BAD_F00D) begin
            bad++;
            $display("FAIL rw_old_value: got %h want %h", bus_if.ram_word, 32'h0BAD_F00D);
        end
        step();
        idle();
        step();
        total++;
        if (range_err !== 1'b1 || misalign_err !== 1'b0) begin
            bad++;
            $display("FAIL rw_range_err: got %b%b want 10", range_err, misalign_err);
        end
        drive(1'b1, 1'b0, 32'h40, 32'h0);
        #1;
        total++;
        if (bus_if.ram_word !== 32'h0BAD_F00D) begin
            bad++;
            $display("FAIL rw_unchanged: got %h want %h", bus_if.ram_word, 32'h0BAD_F00D);
        end
        drive(1'b1, 1'b0, STAT_ADR, 32'h0);
        #1;
        total++;
        if (bus_if.ram_word !== 32'h2) begin
            bad++;
            $display("FAIL stat_read: got %h want %h", bus_if.ram_word, 32'h2);
        end
        step();
        drive(1'b0, 1'b1, STAT_ADR, 32'h0);
        step();
        idle();
        total++;
        if (range_err !== 1'b0) begin
            bad++;
            $display("FAIL rw_clear: got %b want 0", range_err);
        end
    endtask

    // Out-of-range read and dropped out-of-range write (aliases idx 4)
    task automatic test_range();
        drive(1'b1, 1'b0, 32'h1000, 32'h0);
        #1;
        total++;
        if (bus_if.ram_word !== 32'h0) begin
            bad++;
            $display("FAIL range_read_word: got %h want %h", bus_if.ram_word, 32'h0);
        end
        step();
        idle();
        #1;
        total++;
        if (range_err !== 1'b1) begin
            bad++;
            $display("FAIL range_read_err: got %b want 1", range_err);
        end
        drive(0, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b1, STAT_ADR, 32'h0);
        step();
        drive(1'b0, 1'b1, 32'h1010, 32'hDEAD_BEEF);
        step();
        idle();
        total++;
        if (range_err !== 1'b1) begin
            bad++;
            $display("FAIL range_write_err: got %b want 1", range_err);
        end
        step();
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        total++;
        if (bus_if.ram_word !== 32'h1234_5678) begin
            bad++;
            $display("FAIL range_write_dropped: got %h want %h", bus_if.ram_word, 32'h1234_5678);
        end
        step();
        drive(1'b0, 1'b1, STAT_ADR, 32'h0);
        step();
        idle();
    endtask

    // Counter load and wrap
    task automatic test_counter_wrap();
        drive(1'b0, 1'b1, CNT_ADR, 32'hFFFF_FFFE);
        step();
        drive(1'b1, 1'b0, CNT_ADR, 32'h0);
        #1;
        total++;
        if (bus_if.ram_word !== 32'hFFFF_FFFE) begin
            bad++;
            $display("FAIL cnt_load: got %h want %h", bus_if.ram_word, 32'hFFFF_FFFE);
        end
        step();
        total++;
        if (bus_if.ram_word !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL cnt_max: got %h want %h", bus_if.ram_word, 32'hFFFF_FFFF);
        end
        step();
        total++;
        if (bus_if.ram_word !== 32'h0) begin
            bad++;
            $display("FAIL cnt_wrap: got %h want %h", bus_if.ram_word, 32'h0);
        end
        idle();
        step();
    endtask

    // Reset discards a buffered write and clears counter/errors
    task automatic test_reset_discard();
        drive(1'b0, 1'b1, 32'h80, 32'h0000_0011);
        step();
        idle();
        step();
        drive(1'b1, 1'b0, 32'h83, 32'h0);
        step();
        drive(1'b0, 1'b1, 32'h80, 32'h0000_0055);
        step();
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h80, 32'h0);
        #1;
        total++;
        if (bus_if.ram_word !== 32'h0) begin
            bad++;
            $display("FAIL rst_word_zero: got %h want %h", bus_if.ram_word, 32'h0);
        end
        step();
        rst = 1'b0;
        drive(1'b1, 1'b0, CNT_ADR, 32'h0);
        #1;
        total++;
        if (bus_if.ram_word !== 32'h0) begin
            bad++;
            $display("FAIL rst_cnt_zero: got %h want %h", bus_if.ram_word, 32'h0);
        end
        total++;
        if (misalign_err !== 1'b0 || range_err !== 1'b0) begin
            bad++;
            $display("FAIL rst_errs: got %b%b want 00", range_err, misalign_err);
        end
        step();
        drive(1'b1, 1'b0, 32'h80, 32'h0);
        #1;
        total++;
        if (bus_if.ram_word !== 32'h0000_0011) begin
            bad++;
            $display("FAIL rst_discard: got %h want %h", bus_if.ram_word, 32'h0000_0011);
        end
        step();
        idle();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle();
        test_reset();
        test_forwarding();
        test_back_to_back();
        test_misalign();
        test_read_write_conflict();
        test_range();
        test_counter_wrap();
        test_reset_discard();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
